// File: rtl/nes_cpu_bus_master_if.sv
// Host command/response and cartridge CPU bus signals between the bus master and its environment.
interface nes_cpu_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdat;
  logic        rsp_valid;
  logic        rsp_rw;
  logic [7:0]  rsp_data;
  logic        m2;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic        cpu_doe;
  logic [7:0]  cpu_din;
  logic        map_oe;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdat, cpu_din, map_oe,
    output cmd_ready, rsp_valid, rsp_rw, rsp_data, m2, cpu_addr, cpu_rw, cpu_dout, cpu_doe
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdat, cpu_din, map_oe,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_data, m2, cpu_addr, cpu_rw, cpu_dout, cpu_doe
  );
endinterface

// File: rtl/nes_cpu_bus_master.sv
// 6502-style CPU bus initiator: free-running M2, one host command per bus cycle, open-bus read model.
module nes_cpu_bus_master #(
  parameter int unsigned  LO_CLK    = 5,
  parameter int unsigned  HI_CLK    = 7,
  parameter logic [15:0]  IDLE_ADDR = 16'h0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  nes_cpu_bus_master_if.master bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LO_CLK - 1);
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HI_CLK - 1);

  typedef enum logic {PH1 = 1'b0, PH2 = 1'b1} phase_e;

  phase_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_ph2_enter;
  logic               w_cyc_end;
  logic               w_accept;
  logic [DATA_W-1:0]  w_sample;

  logic               r_m2;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rw;
  logic [DATA_W-1:0]  r_dout;
  logic               r_doe;
  logic               r_tag;
  logic               r_ready;
  logic [ADDR_W-1:0]  r_h_addr;
  logic               r_h_rw;
  logic [DATA_W-1:0]  r_h_wdat;
  logic [DATA_W-1:0]  r_ob;
  logic               r_rsp_valid;
  logic               r_rsp_rw;
  logic [DATA_W-1:0]  r_rsp_data;

  // Phase state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= PH1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Phase sequencing; w_cyc_end marks the last PH2 clk (sample point and next cycle start)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_ph2_enter = 1'b0;
    w_cyc_end   = 1'b0;
    case (r_state)
      PH1: if (r_cnt == LO_LAST) begin
        w_state_nxt = PH2;
        w_cnt_nxt   = '0;
        w_ph2_enter = 1'b1;
      end
      PH2: if (r_cnt == HI_LAST) begin
        w_state_nxt = PH1;
        w_cnt_nxt   = '0;
        w_cyc_end   = 1'b1;
      end
      default: begin
        w_state_nxt = PH1;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_accept = bus.cmd_valid & r_ready;
  // Undriven reads return the open-bus value; writes echo their own data
  assign w_sample = r_rw ? (bus.map_oe ? bus.cpu_din : r_ob) : r_dout;

  // Holding register, bus drive, open-bus and response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m2        <= 1'b0;
      r_addr      <= IDLE_ADDR;
      r_rw        <= 1'b1;
      r_dout      <= '0;
      r_doe       <= 1'b0;
      r_tag       <= 1'b0;
      r_ready     <= 1'b1;
      r_h_addr    <= '0;
      r_h_rw      <= 1'b1;
      r_h_wdat    <= '0;
      r_ob        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rw    <= 1'b1;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_ready  <= 1'b0;
        r_h_addr <= bus.cmd_addr;
        r_h_rw   <= bus.cmd_rw;
        r_h_wdat <= bus.cmd_wdat;
      end
      if (w_ph2_enter) begin
        r_m2  <= 1'b1;
        r_doe <= ~r_rw;
      end
      if (w_cyc_end) begin
        r_m2  <= 1'b0;
        r_doe <= 1'b0;
        r_ob  <= w_sample;
        if (r_tag) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rw    <= r_rw;
          r_rsp_data  <= w_sample;
        end
        // Start of next cycle uses pend as it stood before this edge
        if (!r_ready) begin
          r_addr  <= r_h_addr;
          r_rw    <= r_h_rw;
          r_dout  <= r_h_wdat;
          r_tag   <= 1'b1;
          r_ready <= 1'b1;
        end else begin
          r_addr  <= IDLE_ADDR;
          r_rw    <= 1'b1;
          r_dout  <= '0;
          r_tag   <= 1'b0;
        end
      end
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rw    = r_rsp_rw;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.m2        = r_m2;
  assign bus.cpu_addr  = r_addr;
  assign bus.cpu_rw    = r_rw;
  assign bus.cpu_dout  = r_dout;
  assign bus.cpu_doe   = r_doe;
endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Bench for nes_cpu_bus_master: bus monitor, $6000-$7FFF/$8000+ responder, and a command-level reference model.
module tb_nes_cpu_bus_master;
  localparam int unsigned LO  = 5;
  localparam int unsigned HI  = 7;
  localparam int unsigned CYC = LO + HI;
  localparam logic [15:0] IDLE = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nes_cpu_bus_master_if bus ();

  nes_cpu_bus_master #(.LO_CLK(LO), .HI_CLK(HI), .IDLE_ADDR(IDLE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Responder: latches bit6 of writes to $6000-$7FFF, drives reads there and at $8000+ during M2 high
  logic       resp_bit = 1'b0;
  logic [7:0] junk = 8'h00;
  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (bus.cpu_doe === 1'b1 && bus.cpu_addr[15:13] == 3'b011) resp_bit <= bus.cpu_dout[6];
  end

  always_comb begin
    bus.map_oe  = 1'b0;
    bus.cpu_din = junk;
    if (bus.m2 === 1'b1 && bus.cpu_rw === 1'b1) begin
      if (bus.cpu_addr[15:13] == 3'b011) begin
        bus.map_oe  = 1'b1;
        bus.cpu_din = {resp_bit, bus.cpu_addr[14:8]};
      end else if (bus.cpu_addr[15] == 1'b1) begin
        bus.map_oe  = 1'b1;
        bus.cpu_din = bus.cpu_addr[15:8] ^ bus.cpu_addr[7:0];
      end
    end
  end

  // Reference model: commands complete in acceptance order
  typedef struct { logic rw; logic [7:0] data; } exp_t;
  exp_t       exp_q[$];
  logic       m_bit = 1'b0;
  logic [7:0] m_ob = 8'h00;

  function automatic logic [7:0] model_exec(input logic rw, input logic [15:0] a, input logic [7:0] w);
    logic [7:0] d;
    if (!rw) begin
      if (a >= 16'h6000 && a <= 16'h7FFF) m_bit = w[6];
      d = w;
    end else if (a >= 16'h6000 && a <= 16'h7FFF) d = {m_bit, a[14:8]};
    else if (a >= 16'h8000) d = a[15:8] ^ a[7:0];
    else d = m_ob;
    m_ob = d;
    return d;
  endfunction

  // Bus monitor: M2 run lengths, per-cycle records, doe rule, response log
  typedef struct { int stamp; logic [15:0] addr; logic rw; logic [7:0] dout; int doe_cnt; } cyc_t;
  typedef struct { int stamp; logic rw; logic [7:0] data; } rsp_t;
  cyc_t cyc_q[$];
  rsp_t rsp_q[$];
  cyc_t cur;
  logic mon_prev = 1'b0;
  bit   mon_started = 1'b0;
  int   mon_run = 0;
  int   run_viol = 0, runs_seen = 0, stab_viol = 0, doe_viol = 0, rsp_viol = 0, doe_total = 0;

  initial begin
    bit first;
    bit start;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev    = 1'b0;
        mon_run     = 0;
        mon_started = 1'b0;
      end else begin
        first = !mon_started;
        start = first || (mon_prev === 1'b1 && bus.m2 === 1'b0);
        if (bus.m2 === mon_prev) mon_run++;
        else begin
          if (mon_run != int'(mon_prev ? HI : LO)) run_viol++;
          runs_seen++;
          mon_run = 1;
        end
        if (start) begin
          if (!first) cyc_q.push_back(cur);
          cur = '{cyc, bus.cpu_addr, bus.cpu_rw, bus.cpu_dout, 0};
          mon_started = 1'b1;
        end else if (bus.cpu_addr !== cur.addr || bus.cpu_rw !== cur.rw ||
                     (cur.rw === 1'b0 && bus.cpu_dout !== cur.dout)) stab_viol++;
        if (bus.cpu_doe !== (bus.m2 & ~bus.cpu_rw)) doe_viol++;
        if (bus.cpu_doe === 1'b1) begin
          cur.doe_cnt++;
          doe_total++;
        end
        if (bus.rsp_valid === 1'b1) begin
          if (!start || first) rsp_viol++;
          rsp_q.push_back('{cyc, bus.rsp_rw, bus.rsp_data});
        end
        mon_prev = bus.m2;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_m2(input logic lvl);
    int t = 0;
    while (bus.m2 !== lvl && t < 100) begin
      step(1);
      t++;
    end
    chk("m2_wait", 32'(bus.m2), 32'(lvl));
  endtask

  int acc_stamp = 0;

  // Present a command and leave cmd_valid high after the accepting edge
  task automatic present(input logic rw, input logic [15:0] a, input logic [7:0] w);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = a;
    bus.cmd_wdat  = w;
    while (bus.cmd_ready !== 1'b1 && t < 200) begin
      step(1);
      t++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    step(1);
    acc_stamp = cyc;
    exp_q.push_back('{rw, model_exec(rw, a, w)});
  endtask

  task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] w);
    present(rw, a, w);
    bus.cmd_valid = 1'b0;
  endtask

  int   stamps[$];
  logic [7:0] last_data = 8'h00;

  task automatic expect_rsps(input int n, input string tag);
    int   t = 0;
    rsp_t r;
    exp_t e;
    while (rsp_q.size() < n && t < 3000) begin
      step(1);
      t++;
    end
    chk({tag, "_rsp_count"}, 32'(rsp_q.size()), 32'(n));
    stamps.delete();
    for (int i = 0; i < n; i++) begin
      if (rsp_q.size() == 0 || exp_q.size() == 0) break;
      r = rsp_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_rw"}, 32'(r.rw), 32'(e.rw));
      chk({tag, "_data"}, 32'(r.data), 32'(e.data));
      last_data = r.data;
      stamps.push_back(r.stamp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nonidle;
    int runs0;
    int bad;
    int idle_ok;
    int cmd_ok;
    int sel;
    logic [15:0] ra;
    logic        rrw;
    logic [7:0]  rwd;

    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b1;
    bus.cmd_addr  = 16'h0000;
    bus.cmd_wdat  = 8'h00;

    // Power-on reset values
    step(3);
    rst = 1'b0;
    chk("rst_m2", 32'(bus.m2), 32'd0);
    chk("rst_addr", 32'(bus.cpu_addr), 32'(IDLE));
    chk("rst_rw", 32'(bus.cpu_rw), 32'd1);
    chk("rst_doe", 32'(bus.cpu_doe), 32'd0);
    chk("rst_dout", 32'(bus.cpu_dout), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_rw", 32'(bus.rsp_rw), 32'd1);

    // Reset mid-PH2 with a command pending: dropped, bus back to idle next clk
    wait_m2(1'b1);
    step(2);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = 16'h6000;
    bus.cmd_wdat  = 8'hFF;
    step(1);
    bus.cmd_valid = 1'b0;
    chk("pend_before_rst", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b1;
    step(1);
    chk("midrst_m2", 32'(bus.m2), 32'd0);
    chk("midrst_rw", 32'(bus.cpu_rw), 32'd1);
    chk("midrst_addr", 32'(bus.cpu_addr), 32'(IDLE));
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step(2);
    rst = 1'b0;
    cyc_q.delete();
    rsp_q.delete();
    runs0 = runs_seen;

    // Idle period
    step(4 * CYC + 2);
    chk("idle_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("idle_cycles_seen", 32'(cyc_q.size() >= 4), 32'd1);
    nonidle = 0;
    foreach (cyc_q[i]) if (cyc_q[i].addr !== IDLE || cyc_q[i].rw !== 1'b1) nonidle++;
    chk("idle_addr_rw", 32'(nonidle), 32'd0);
    chk("idle_runs_seen", 32'(runs_seen - runs0 >= 8), 32'd1);
    chk("idle_run_len", 32'(run_viol), 32'd0);
    chk("idle_doe_never", 32'(doe_total), 32'd0);
    chk("dropped_write_bit", 32'(resp_bit), 32'd0);

    // Directed window write/read
    send(1'b0, 16'h6000, 8'h40);
    expect_rsps(1, "w6000_40");
    chk("w40_doe_clks", 32'(cyc_q[cyc_q.size()-1].doe_cnt), 32'(HI));
    chk("w40_dout", 32'(cyc_q[cyc_q.size()-1].dout), 32'h40);
    chk("w40_addr", 32'(cyc_q[cyc_q.size()-1].addr), 32'h6000);
    send(1'b1, 16'h7FFF, 8'h00);
    expect_rsps(1, "r7fff");
    chk("r7fff_lit", 32'(last_data), 32'hFF);
    send(1'b0, 16'h6000, 8'h00);
    expect_rsps(1, "w6000_00");
    send(1'b1, 16'h6000, 8'h00);
    expect_rsps(1, "r6000");
    chk("r6000_lit", 32'(last_data), 32'h60);

    // Open bus
    send(1'b0, 16'h4020, 8'h5A);
    expect_rsps(1, "w4020");
    send(1'b1, 16'h4020, 8'h00);
    expect_rsps(1, "ob_after_write");
    chk("ob_5a_lit", 32'(last_data), 32'h5A);
    send(1'b1, 16'h6000, 8'h00);
    expect_rsps(1, "ob_driven");
    send(1'b1, 16'h4020, 8'h00);
    expect_rsps(1, "ob_after_read");
    chk("ob_60_lit", 32'(last_data), 32'h60);

    // Back-to-back commands with cmd_valid held
    present(1'b0, 16'h6001, 8'h81);
    present(1'b1, 16'h6002, 8'h00);
    present(1'b1, 16'h8034, 8'h00);
    bus.cmd_valid = 1'b0;
    expect_rsps(3, "b2b");
    if (stamps.size() == 3) begin
      chk("b2b_gap0", 32'(stamps[1] - stamps[0]), 32'(CYC));
      chk("b2b_gap1", 32'(stamps[2] - stamps[1]), 32'(CYC));
    end
    chk("b2b_cyc_addr0", 32'(cyc_q[cyc_q.size()-3].addr), 32'h6001);
    chk("b2b_cyc_addr1", 32'(cyc_q[cyc_q.size()-2].addr), 32'h6002);
    chk("b2b_cyc_addr2", 32'(cyc_q[cyc_q.size()-1].addr), 32'h8034);

    // Accept on the cycle-start edge: issued one cycle later
    wait_m2(1'b0);
    wait_m2(1'b1);
    step(HI - 1);
    present(1'b1, 16'h8123, 8'h00);
    bus.cmd_valid = 1'b0;
    chk("samestart_ready_low", 32'(bus.cmd_ready), 32'd0);
    bad = 0;
    for (int i = 1; i < int'(CYC); i++) begin
      step(1);
      if (bus.cmd_ready !== 1'b0) bad++;
    end
    chk("samestart_ready_held", 32'(bad), 32'd0);
    step(1);
    chk("samestart_ready_free", 32'(bus.cmd_ready), 32'd1);
    expect_rsps(1, "samestart");
    if (stamps.size() == 1) chk("samestart_rsp_time", 32'(stamps[0] - acc_stamp), 32'(2 * CYC));
    idle_ok = 0;
    cmd_ok  = 0;
    foreach (cyc_q[i]) begin
      if (cyc_q[i].stamp == acc_stamp && cyc_q[i].addr === IDLE && cyc_q[i].rw === 1'b1) idle_ok = 1;
      if (cyc_q[i].stamp == acc_stamp + int'(CYC) && cyc_q[i].addr === 16'h8123) cmd_ok = 1;
    end
    chk("samestart_cur_idle", 32'(idle_ok), 32'd1);
    chk("samestart_next_cmd", 32'(cmd_ok), 32'd1);

    // Randomized commands against the model
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       ra = 16'h6000 | 16'($urandom_range(0, 16'h1FFF));
        1:       ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        2:       ra = 16'h4020 + 16'($urandom_range(0, 31));
        default: ra = 16'($urandom_range(0, 16'h5FFF));
      endcase
      rrw = 1'($urandom_range(0, 1));
      rwd = 8'($urandom);
      send(rrw, ra, rwd);
      step(int'($urandom_range(0, 15)));
    end
    expect_rsps(40, "rnd");

    chk("final_run_len", 32'(run_viol), 32'd0);
    chk("final_addr_stable", 32'(stab_viol), 32'd0);
    chk("final_doe_rule", 32'(doe_viol), 32'd0);
    chk("final_rsp_at_start", 32'(rsp_viol), 32'd0);
    chk("final_exp_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
